rgb_fade_sequencer: RTL and testbench

Autonomous colour-sequence controller that drives the three duty inputs and the enable of the team's RGB PWM driver. It holds a small programmable colour table. It ramps the current red, green and blue duties one LSB per step toward the active entry, dwells at that entry, then advances to the next entry with wrap-around. It sits between the register/host interface and the RGB PWM driver.

---
 rtl/rgb_seq_pkg.sv | 20 ++
 rtl/rgb_seq_channel_stepper.sv | 36 +++
 rtl/rgb_fade_sequencer.sv | 144 ++++++++++++++
 tb/tb_rgb_fade_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_seq_pkg.sv
// Shared types and defaults for the RGB fade sequencer.
// The optional RGB_SEQ_WRAP_IRQ_EN feature is handled in rgb_fade_sequencer.sv.
package rgb_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_FADE = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

  localparam int R_DEF         = 8;
  localparam int ENTRIES_DEF   = 4;
  localparam int TICK_BITS_DEF = 16;
  localparam int DUTY_MAX_DEF  = 1 << R_DEF;

  function automatic int idx_w(input int entries);
    return (entries < 2) ? 1 : $clog2(entries);
  endfunction

endpackage

// File: rtl/rgb_seq_channel_stepper.sv
// One colour channel: duty register that moves one LSB toward its target per step.
// o_at_target compares the post-step duty so the FSM can leave FADE on the step edge.
import rgb_seq_pkg::*;

module rgb_seq_channel_stepper #(
  parameter int R = R_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_step,
  input  logic [R:0] i_target,
  output logic [R:0] o_duty,
  output logic       o_at_target
);

  logic [R:0] r_duty;
  logic [R:0] w_next;

  // Targets are saturated to 2^R on write, so the duty can never leave 0..2^R.
  always_comb begin
    w_next = r_duty;
    if (i_step) begin
      if (r_duty < i_target)      w_next = r_duty + (R+1)'(1);
      else if (r_duty > i_target) w_next = r_duty - (R+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_duty <= '0;
    else          r_duty <= w_next;
  end

  assign o_duty      = r_duty;
  assign o_at_target = (w_next == i_target);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Colour-table sequencer: FADE toward table[index], HOLD, advance with wrap.
// Define RGB_SEQ_WRAP_IRQ_EN to add the seq_done pulse on the index wrap.
import rgb_seq_pkg::*;

module rgb_fade_sequencer #(
  parameter  int R         = R_DEF,
  parameter  int ENTRIES   = ENTRIES_DEF,
  parameter  int TICK_BITS = TICK_BITS_DEF,
  localparam int IDX_W     = idx_w(ENTRIES)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_addr,
  input  logic [R:0]           wr_red,
  input  logic [R:0]           wr_green,
  input  logic [R:0]           wr_blue,
  input  logic [TICK_BITS-1:0] step_period,
  input  logic [TICK_BITS-1:0] hold_period,
  output logic [R:0]           red_duty,
  output logic [R:0]           green_duty,
  output logic [R:0]           blue_duty,
  output logic                 pwm_enable,
  output logic [IDX_W-1:0]     index,
  output logic                 at_target,
  output state_t               dbg_state
`ifdef RGB_SEQ_WRAP_IRQ_EN
  ,
  output logic                 seq_done
`endif
);

  localparam logic [R:0] DUTY_MAX = {1'b1, {R{1'b0}}};

  state_t               r_state;
  logic [TICK_BITS-1:0] r_cnt;
  logic [IDX_W-1:0]     r_index;
  logic                 r_pwm_en;
  logic                 r_at_target;
  logic [R:0]           r_tab_r [ENTRIES];
  logic [R:0]           r_tab_g [ENTRIES];
  logic [R:0]           r_tab_b [ENTRIES];
  logic                 w_step;
  logic [2:0]           w_eq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_tab_r[i] <= '0;
        r_tab_g[i] <= '0;
        r_tab_b[i] <= '0;
      end
    end else if (wr_en) begin
      r_tab_r[wr_addr] <= (wr_red   > DUTY_MAX) ? DUTY_MAX : wr_red;
      r_tab_g[wr_addr] <= (wr_green > DUTY_MAX) ? DUTY_MAX : wr_green;
      r_tab_b[wr_addr] <= (wr_blue  > DUTY_MAX) ? DUTY_MAX : wr_blue;
    end
  end

  // stop gates the step so the duties freeze at their pre-stop values.
  assign w_step = (r_state == ST_FADE) && !stop && (r_cnt == step_period);

  rgb_seq_channel_stepper #(.R(R)) u_red (
    .clk(clk), .reset_n(reset_n), .i_step(w_step), .i_target(r_tab_r[r_index]),
    .o_duty(red_duty), .o_at_target(w_eq[0])
  );
  rgb_seq_channel_stepper #(.R(R)) u_green (
    .clk(clk), .reset_n(reset_n), .i_step(w_step), .i_target(r_tab_g[r_index]),
    .o_duty(green_duty), .o_at_target(w_eq[1])
  );
  rgb_seq_channel_stepper #(.R(R)) u_blue (
    .clk(clk), .reset_n(reset_n), .i_step(w_step), .i_target(r_tab_b[r_index]),
    .o_duty(blue_duty), .o_at_target(w_eq[2])
  );

`ifdef RGB_SEQ_WRAP_IRQ_EN
  logic r_seq_done;
  assign seq_done = r_seq_done;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_index     <= '0;
      r_pwm_en    <= 1'b0;
      r_at_target <= 1'b0;
`ifdef RGB_SEQ_WRAP_IRQ_EN
      r_seq_done  <= 1'b0;
`endif
    end else begin
      r_at_target <= 1'b0;
`ifdef RGB_SEQ_WRAP_IRQ_EN
      r_seq_done  <= 1'b0;
`endif
      if (stop) begin
        r_state  <= ST_IDLE;
        r_cnt    <= '0;
        r_pwm_en <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: if (start) begin
            r_state  <= ST_FADE;
            r_index  <= '0;
            r_cnt    <= '0;
            r_pwm_en <= 1'b1;
          end
          ST_FADE: begin
            if (&w_eq) begin
              r_state     <= ST_HOLD;
              r_cnt       <= '0;
              r_at_target <= 1'b1;
            end else if (r_cnt == step_period) begin
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + TICK_BITS'(1);
            end
          end
          ST_HOLD: begin
            if (r_cnt == hold_period) begin
              r_state <= ST_FADE;
              r_cnt   <= '0;
              r_index <= r_index + IDX_W'(1);
`ifdef RGB_SEQ_WRAP_IRQ_EN
              r_seq_done <= (r_index == IDX_W'(ENTRIES - 1));
`endif
            end else begin
              r_cnt <= r_cnt + TICK_BITS'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign pwm_enable = r_pwm_en;
  assign index      = r_index;
  assign at_target  = r_at_target;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer: a per-cycle vector table plus
// hand-written multi-cycle sequences (ramps, stop/restart, reversal, async reset).
import rgb_seq_pkg::*;

module tb_rgb_fade_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, stop, wr_en;
  logic [1:0]  wr_addr;
  logic [8:0]  wr_red, wr_green, wr_blue;
  logic [15:0] step_period, hold_period;
  logic [8:0]  red_duty, green_duty, blue_duty;
  logic        pwm_enable, at_target;
  logic [1:0]  index;
  state_t      dbg_state;
`ifdef RGB_SEQ_WRAP_IRQ_EN
  logic        seq_done;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  rgb_fade_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_red(wr_red), .wr_green(wr_green),
    .wr_blue(wr_blue), .step_period(step_period), .hold_period(hold_period),
    .red_duty(red_duty), .green_duty(green_duty), .blue_duty(blue_duty),
    .pwm_enable(pwm_enable), .index(index), .at_target(at_target),
    .dbg_state(dbg_state)
`ifdef RGB_SEQ_WRAP_IRQ_EN
    , .seq_done(seq_done)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_red = '0; wr_green = '0; wr_blue = '0;
    step_period = '0; hold_period = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  task automatic chk_outs(input string tag, input int st, input int pwm, input int idx,
                          input int at, input int r, input int g, input int b);
    chk({tag, " state"},     int'(dbg_state),  st);
    chk({tag, " pwm"},       int'(pwm_enable), pwm);
    chk({tag, " index"},     int'(index),      idx);
    chk({tag, " at_target"}, int'(at_target),  at);
    chk({tag, " red"},       int'(red_duty),   r);
    chk({tag, " green"},     int'(green_duty), g);
    chk({tag, " blue"},      int'(blue_duty),  b);
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_entry(input int a, input int r, input int g, input int b);
    wr_en = 1'b1; wr_addr = 2'(a); wr_red = 9'(r); wr_green = 9'(g); wr_blue = 9'(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  typedef struct {
    int start, stop, wr_en, wr_addr, wr_r, wr_g, wr_b;
    int e_state, e_pwm, e_idx, e_at, e_r, e_g, e_b, e_done;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int done_cnt;

    // step_period=0, hold_period=0 walk through all four entries, then start-ignored, stop, start+stop
    vecs[0]  = '{0,0,1,0,2,1,0, ST_IDLE,0,0,0, 0,0,0, 0};
    vecs[1]  = '{0,0,1,1,1,1,1, ST_IDLE,0,0,0, 0,0,0, 0};
    vecs[2]  = '{1,0,0,0,0,0,0, ST_FADE,1,0,0, 0,0,0, 0};
    vecs[3]  = '{0,0,0,0,0,0,0, ST_FADE,1,0,0, 1,1,0, 0};
    vecs[4]  = '{0,0,0,0,0,0,0, ST_HOLD,1,0,1, 2,1,0, 0};
    vecs[5]  = '{0,0,0,0,0,0,0, ST_FADE,1,1,0, 2,1,0, 0};
    vecs[6]  = '{0,0,0,0,0,0,0, ST_HOLD,1,1,1, 1,1,1, 0};
    vecs[7]  = '{0,0,0,0,0,0,0, ST_FADE,1,2,0, 1,1,1, 0};
    vecs[8]  = '{0,0,0,0,0,0,0, ST_HOLD,1,2,1, 0,0,0, 0};
    vecs[9]  = '{0,0,0,0,0,0,0, ST_FADE,1,3,0, 0,0,0, 0};
    vecs[10] = '{0,0,0,0,0,0,0, ST_HOLD,1,3,1, 0,0,0, 0};
    vecs[11] = '{0,0,0,0,0,0,0, ST_FADE,1,0,0, 0,0,0, 1};
    vecs[12] = '{1,0,0,0,0,0,0, ST_FADE,1,0,0, 1,1,0, 0};
    vecs[13] = '{0,1,0,0,0,0,0, ST_IDLE,0,0,0, 1,1,0, 0};
    vecs[14] = '{1,1,0,0,0,0,0, ST_IDLE,0,0,0, 1,1,0, 0};
    vecs[15] = '{0,0,0,0,0,0,0, ST_IDLE,0,0,0, 1,1,0, 0};

    // reset values
    do_reset();
    chk_outs("reset", ST_IDLE, 0, 0, 0, 0, 0, 0);

    // ---------------- vector table ----------------
    for (int i = 0; i < 16; i++) begin
      start = 1'(vecs[i].start); stop = 1'(vecs[i].stop); wr_en = 1'(vecs[i].wr_en);
      wr_addr = 2'(vecs[i].wr_addr);
      wr_red = 9'(vecs[i].wr_r); wr_green = 9'(vecs[i].wr_g); wr_blue = 9'(vecs[i].wr_b);
      tick();
      chk_outs($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_pwm, vecs[i].e_idx,
               vecs[i].e_at, vecs[i].e_r, vecs[i].e_g, vecs[i].e_b);
`ifdef RGB_SEQ_WRAP_IRQ_EN
      chk($sformatf("vec%0d seq_done", i), int'(seq_done), vecs[i].e_done);
`endif
    end
    start = 1'b0; stop = 1'b0; wr_en = 1'b0;

    // ---------------- ramp up, hold 4 cycles, ramp down, saturated write ----------------
    do_reset();
    hold_period = 16'd3;
    write_entry(0, 10, 0, 256);
    write_entry(1, 0, 5, 256);
    write_entry(2, 300, 5, 256);
    pulse_start();
    chk_outs("t1 start", ST_FADE, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 256; k++) begin
      tick();
      chk_outs($sformatf("t1 k=%0d", k), (k == 256) ? ST_HOLD : ST_FADE, 1, 0,
               (k == 256) ? 1 : 0, (k < 10) ? k : 10, 0, k);
    end
    for (int j = 1; j <= 4; j++) begin
      tick();
      chk_outs($sformatf("t2 hold j=%0d", j), (j == 4) ? ST_FADE : ST_HOLD, 1,
               (j == 4) ? 1 : 0, 0, 10, 0, 256);
    end
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk_outs($sformatf("t2 fade j=%0d", j), (j == 10) ? ST_HOLD : ST_FADE, 1, 1,
               (j == 10) ? 1 : 0, 10 - j, (j < 5) ? j : 5, 256);
    end
    repeat (4) tick();
    chk_outs("t5 sat entry", ST_FADE, 1, 2, 0, 0, 5, 256);
    for (int k = 1; k <= 258; k++) begin
      tick();
      chk_outs($sformatf("t5 sat k=%0d", k), (k >= 256 && k <= 259) ? ST_HOLD : ST_FADE, 1, 2,
               (k == 256) ? 1 : 0, (k < 256) ? k : 256, 5, 256);
    end

    // ---------------- index walk with all entries equal to the duties ----------------
    do_reset();
    pulse_start();
    done_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("t3 index c=%0d", c), int'(index), (c / 2) % 4);
      chk($sformatf("t3 state c=%0d", c), int'(dbg_state), (c % 2 == 1) ? ST_HOLD : ST_FADE);
      chk($sformatf("t3 at_target c=%0d", c), int'(at_target), c % 2);
`ifdef RGB_SEQ_WRAP_IRQ_EN
      chk($sformatf("t3 seq_done c=%0d", c), int'(seq_done), (c == 8) ? 1 : 0);
      done_cnt += int'(seq_done);
`endif
    end
`ifdef RGB_SEQ_WRAP_IRQ_EN
    chk("t3 seq_done count", done_cnt, 1);
`endif

    // ---------------- stop mid-FADE at red=7, restart from entry 0 ----------------
    do_reset();
    write_entry(1, 20, 0, 0);
    pulse_start();
    repeat (9) tick();
    chk_outs("t4 before stop", ST_FADE, 1, 1, 0, 7, 0, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_outs("t4 stopped", ST_IDLE, 0, 1, 0, 7, 0, 0);
    tick();
    chk_outs("t4 idle", ST_IDLE, 0, 1, 0, 7, 0, 0);
    pulse_start();
    chk_outs("t4 restart", ST_FADE, 1, 0, 0, 7, 0, 0);
    tick();
    chk_outs("t4 restart step", ST_FADE, 1, 0, 0, 6, 0, 0);

    // ---------------- step_period=4, live target change, async reset in HOLD ----------------
    do_reset();
    step_period = 16'd4;
    hold_period = 16'd100;
    write_entry(0, 10, 0, 0);
    pulse_start();
    for (int t = 1; t <= 15; t++) begin
      tick();
      chk($sformatf("t6 red t=%0d", t), int'(red_duty), t / 5);
    end
    write_entry(0, 2, 0, 0);
    for (int t = 17; t <= 20; t++) begin
      tick();
      chk($sformatf("t6 rev red t=%0d", t), int'(red_duty), (t < 20) ? 3 : 2);
      chk($sformatf("t6 rev state t=%0d", t), int'(dbg_state), (t < 20) ? ST_FADE : ST_HOLD);
    end
    chk("t6 at_target", int'(at_target), 1);
    tick(); tick();
    chk_outs("t6 in hold", ST_HOLD, 1, 0, 0, 2, 0, 0);
    reset_n = 1'b0;
    #1;
    chk_outs("t6 async reset", ST_IDLE, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
